map_table_ckpt: RTL and testbench

- Parametrised R10K-style rename map table: N-wide dispatch, M CDB channels, NUM_CKPT branch checkpoints.
- Translates architectural source/destination registers to physical tags and tracks per-mapping ready bits.
- Snapshots the map and ready bits per branch. Restores a snapshot on mispredict, or restores the full retirement map on exception recovery.
- Sits between decode/free-list and RS/ROB in dispatch.

---
 rtl/map_table_ckpt.sv | 206 ++++++++++++++++++++
 tb/tb_map_table_ckpt.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/map_table_ckpt.sv
// R10K-style rename map table with branch checkpoints.
// Optional same-cycle CDB bypass on source ready: `define MT_CDB_BYPASS_EN.
//
// Ports:
//   clk, rst (sync, active low)
//   dis_*              : N-wide dispatch group (dest/src arch regs, new tags, branch flags)
//   src1/src2_tag/_rdy : renamed sources; old_tag: previous dest mapping
//   ckpt_id            : checkpoint assigned to each branch slot
//   ckpt_free_cnt      : free checkpoints
//   cdb_valid/cdb_tag  : completion broadcasts
//   ckpt_retire        : release the oldest checkpoint
//   br_mispredict/br_id: restore a checkpoint
//   rec_enable/rec_tbl : full restore from the retirement map
module map_table_ckpt #(
   parameter int DISPATCH_WIDTH      = 3,
   parameter int CDB_WIDTH           = 3,
   parameter int PHYS_REG_ADDR_WIDTH = 6,
   parameter int NUM_CKPT            = 4,
   parameter int CKPT_ID_WIDTH       = 2
) (
   input  logic                                                 clk,
   input  logic                                                 rst,
   input  logic [DISPATCH_WIDTH-1:0]                            dis_valid,
   input  logic [DISPATCH_WIDTH-1:0][4:0]                       dis_dest_arch,
   input  logic [DISPATCH_WIDTH-1:0][PHYS_REG_ADDR_WIDTH-1:0]   dis_new_tag,
   input  logic [DISPATCH_WIDTH-1:0][4:0]                       dis_src1_arch,
   input  logic [DISPATCH_WIDTH-1:0][4:0]                       dis_src2_arch,
   input  logic [DISPATCH_WIDTH-1:0]                            dis_is_branch,
   output logic [DISPATCH_WIDTH-1:0][PHYS_REG_ADDR_WIDTH-1:0]   src1_tag,
   output logic [DISPATCH_WIDTH-1:0][PHYS_REG_ADDR_WIDTH-1:0]   src2_tag,
   output logic [DISPATCH_WIDTH-1:0]                            src1_rdy,
   output logic [DISPATCH_WIDTH-1:0]                            src2_rdy,
   output logic [DISPATCH_WIDTH-1:0][PHYS_REG_ADDR_WIDTH-1:0]   old_tag,
   output logic [DISPATCH_WIDTH-1:0][CKPT_ID_WIDTH-1:0]         ckpt_id,
   output logic [CKPT_ID_WIDTH:0]                               ckpt_free_cnt,
   input  logic [CDB_WIDTH-1:0]                                 cdb_valid,
   input  logic [CDB_WIDTH-1:0][PHYS_REG_ADDR_WIDTH-1:0]        cdb_tag,
   input  logic                                                 ckpt_retire,
   input  logic                                                 br_mispredict,
   input  logic [CKPT_ID_WIDTH-1:0]                             br_id,
   input  logic                                                 rec_enable,
   input  logic [31:0][PHYS_REG_ADDR_WIDTH-1:0]                 rec_tbl
);
   localparam int DW = DISPATCH_WIDTH;
   localparam int PW = PHYS_REG_ADDR_WIDTH;
   localparam int CW = CKPT_ID_WIDTH;

   typedef logic [PW-1:0] tag_t;

   tag_t        map_q [32];
   logic [31:0] rdy_q;
   tag_t        ck_map_q [NUM_CKPT][32];
   logic [31:0] ck_rdy_q [NUM_CKPT];
   logic [CW:0] head_q, tail_q;

   tag_t        map_n [32];
   logic [31:0] rdy_n;
   tag_t        ck_map_n [NUM_CKPT][32];
   logic [31:0] ck_rdy_n [NUM_CKPT];
   logic [CW:0] head_n, tail_n;

   tag_t        w_map [32];
   logic [31:0] w_rdy;
   logic [31:0] fwd;
   logic [31:0] live_hit;
   logic [CW:0] count, free, bcnt, mp_ptr;
   logic        dis_ok;
   int          breq;

   function automatic logic cdb_hit(input logic [CDB_WIDTH-1:0] v,
                                    input logic [CDB_WIDTH-1:0][PW-1:0] t,
                                    input tag_t q);
      logic h;
      h = 1'b0;
      for (int c = 0; c < CDB_WIDTH; c++)
         if (v[c] && t[c] == q) h = 1'b1;
      return h;
   endfunction

   always_comb begin
      count  = tail_q - head_q;
      free   = (CW+1)'(NUM_CKPT) - count;
      dis_ok = !rec_enable && !br_mispredict;

      live_hit = '0;
      for (int a = 0; a < 32; a++)
         live_hit[a] = cdb_hit(cdb_valid, cdb_tag, map_q[a]);

      ck_map_n = ck_map_q;
      for (int k = 0; k < NUM_CKPT; k++) begin
         ck_rdy_n[k] = ck_rdy_q[k];
         for (int a = 0; a < 32; a++)
            if (cdb_hit(cdb_valid, cdb_tag, ck_map_q[k][a]))
               ck_rdy_n[k][a] = 1'b1;
      end

      // Working copy walks the group in order: slot j sees slots 0..j-1.
      w_map = map_q;
      w_rdy = rdy_q | live_hit;
      fwd   = '0;
      bcnt  = '0;
      breq  = 0;
      src1_tag = '0;
      src2_tag = '0;
      src1_rdy = '0;
      src2_rdy = '0;
      old_tag  = '0;
      ckpt_id  = '0;

      for (int j = 0; j < DW; j++) begin
         if (dis_src1_arch[j] == 5'd0) begin
            src1_tag[j] = '0;
            src1_rdy[j] = 1'b1;
         end else begin
            src1_tag[j] = w_map[dis_src1_arch[j]];
`ifdef MT_CDB_BYPASS_EN
            src1_rdy[j] = !fwd[dis_src1_arch[j]] &&
                          (rdy_q[dis_src1_arch[j]] || live_hit[dis_src1_arch[j]]);
`else
            src1_rdy[j] = !fwd[dis_src1_arch[j]] && rdy_q[dis_src1_arch[j]];
`endif
         end

         if (dis_src2_arch[j] == 5'd0) begin
            src2_tag[j] = '0;
            src2_rdy[j] = 1'b1;
         end else begin
            src2_tag[j] = w_map[dis_src2_arch[j]];
`ifdef MT_CDB_BYPASS_EN
            src2_rdy[j] = !fwd[dis_src2_arch[j]] &&
                          (rdy_q[dis_src2_arch[j]] || live_hit[dis_src2_arch[j]]);
`else
            src2_rdy[j] = !fwd[dis_src2_arch[j]] && rdy_q[dis_src2_arch[j]];
`endif
         end

         old_tag[j] = (dis_dest_arch[j] == 5'd0) ? '0 : w_map[dis_dest_arch[j]];
         ckpt_id[j] = tail_q[CW-1:0] + bcnt[CW-1:0];

         if (dis_valid[j] && dis_dest_arch[j] != 5'd0) begin
            w_map[dis_dest_arch[j]] = dis_new_tag[j];
            w_rdy[dis_dest_arch[j]] = 1'b0;
            fwd[dis_dest_arch[j]]   = 1'b1;
         end

         if (dis_valid[j] && dis_is_branch[j]) begin
            breq = breq + 1;
            if (bcnt < free) begin
               if (dis_ok) begin
                  ck_map_n[ckpt_id[j]] = w_map;
                  ck_rdy_n[ckpt_id[j]] = w_rdy;
               end
               bcnt = bcnt + 1'b1;
            end
         end
      end

      // br_id lies between head and tail; recover its wrap bit from head.
      mp_ptr = {(br_id >= head_q[CW-1:0]) ? head_q[CW] : ~head_q[CW], br_id};

      map_n  = w_map;
      rdy_n  = w_rdy;
      head_n = head_q;
      tail_n = tail_q + bcnt;
      if (ckpt_retire && count != '0)
         head_n = head_q + 1'b1;

      if (rec_enable) begin
         for (int a = 0; a < 32; a++)
            map_n[a] = rec_tbl[a];
         rdy_n  = '1;
         head_n = '0;
         tail_n = '0;
      end else if (br_mispredict) begin
         map_n  = ck_map_q[br_id];
         rdy_n  = ck_rdy_n[br_id];
         tail_n = mp_ptr + 1'b1;
      end

      ckpt_free_cnt = free;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int a = 0; a < 32; a++)
            map_q[a] <= tag_t'(a);
         rdy_q  <= '1;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         map_q  <= map_n;
         rdy_q  <= rdy_n;
         head_q <= head_n;
         tail_q <= tail_n;
         if (dis_ok)
            assert (breq <= int'(free))
               else $error("map_table_ckpt: branch group exceeds free checkpoints");
      end
   end

   always_ff @(posedge clk) begin
      ck_map_q <= ck_map_n;
      ck_rdy_q <= ck_rdy_n;
   end

endmodule

// File: tb/tb_map_table_ckpt.sv
// Directed self-checking bench for map_table_ckpt.
// Drives after each rising edge, checks combinational outputs on the falling edge.
module tb_map_table_ckpt;
   logic                  clk = 1'b0;
   logic                  rst;
   logic [2:0]            dis_valid;
   logic [2:0][4:0]       dis_dest_arch;
   logic [2:0][5:0]       dis_new_tag;
   logic [2:0][4:0]       dis_src1_arch;
   logic [2:0][4:0]       dis_src2_arch;
   logic [2:0]            dis_is_branch;
   logic [2:0][5:0]       src1_tag;
   logic [2:0][5:0]       src2_tag;
   logic [2:0]            src1_rdy;
   logic [2:0]            src2_rdy;
   logic [2:0][5:0]       old_tag;
   logic [2:0][1:0]       ckpt_id;
   logic [2:0]            ckpt_free_cnt;
   logic [2:0]            cdb_valid;
   logic [2:0][5:0]       cdb_tag;
   logic                  ckpt_retire;
   logic                  br_mispredict;
   logic [1:0]            br_id;
   logic                  rec_enable;
   logic [31:0][5:0]      rec_tbl;

   int ncmp  = 0;
   int nfail = 0;

`ifdef MT_CDB_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   map_table_ckpt dut (
      .clk(clk), .rst(rst),
      .dis_valid(dis_valid), .dis_dest_arch(dis_dest_arch),
      .dis_new_tag(dis_new_tag), .dis_src1_arch(dis_src1_arch),
      .dis_src2_arch(dis_src2_arch), .dis_is_branch(dis_is_branch),
      .src1_tag(src1_tag), .src2_tag(src2_tag),
      .src1_rdy(src1_rdy), .src2_rdy(src2_rdy),
      .old_tag(old_tag), .ckpt_id(ckpt_id), .ckpt_free_cnt(ckpt_free_cnt),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
      .ckpt_retire(ckpt_retire), .br_mispredict(br_mispredict), .br_id(br_id),
      .rec_enable(rec_enable), .rec_tbl(rec_tbl)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp)
         else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", nm, obs, exp);
         end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clr;
      dis_valid     = '0;
      dis_dest_arch = '0;
      dis_new_tag   = '0;
      dis_src1_arch = '0;
      dis_src2_arch = '0;
      dis_is_branch = '0;
      cdb_valid     = '0;
      cdb_tag       = '0;
      ckpt_retire   = 1'b0;
      br_mispredict = 1'b0;
      br_id         = '0;
      rec_enable    = 1'b0;
      for (int i = 0; i < 32; i++) rec_tbl[i] = 6'(i);
   endtask

   initial begin
      clr;
      rst = 1'b0;
      tick;
      tick;
      dis_src1_arch[0] = 5'd7;
      @(negedge clk);
      chk("rst_free", ckpt_free_cnt, 4);
      chk("rst_r7_tag", src1_tag[0], 7);
      chk("rst_r7_rdy", src1_rdy[0], 1);
      rst = 1'b1;

      // group with intra-group forwarding
      tick;
      clr;
      dis_valid = 3'b111;
      dis_dest_arch[0] = 1; dis_dest_arch[1] = 2; dis_dest_arch[2] = 3;
      dis_new_tag[0] = 10;  dis_new_tag[1] = 11;  dis_new_tag[2] = 12;
      dis_src1_arch[0] = 1; dis_src1_arch[1] = 2; dis_src1_arch[2] = 3;
      dis_src2_arch[0] = 0; dis_src2_arch[1] = 1; dis_src2_arch[2] = 2;
      @(negedge clk);
      chk("g1_s1t0", src1_tag[0], 1);
      chk("g1_s1t1", src1_tag[1], 2);
      chk("g1_s1t2", src1_tag[2], 3);
      chk("g1_s1rdy", src1_rdy, 3'b111);
      chk("g1_s2t0", src2_tag[0], 0);
      chk("g1_s2t1", src2_tag[1], 10);
      chk("g1_s2t2", src2_tag[2], 11);
      chk("g1_s2rdy", src2_rdy, 3'b001);
      chk("g1_old0", old_tag[0], 1);
      chk("g1_old1", old_tag[1], 2);
      chk("g1_old2", old_tag[2], 3);

      // read back + CDB of 11 and 12
      tick;
      clr;
      dis_src1_arch[0] = 1; dis_src1_arch[1] = 2; dis_src1_arch[2] = 3;
      cdb_valid = 3'b011; cdb_tag[0] = 11; cdb_tag[1] = 12;
      @(negedge clk);
      chk("rd_r1_tag", src1_tag[0], 10);
      chk("rd_r1_rdy", src1_rdy[0], 0);
      chk("rd_r2_tag", src1_tag[1], 11);
      chk("cdb_r2_same", src1_rdy[1], BYP);
      chk("cdb_r3_same", src1_rdy[2], BYP);

      tick;
      cdb_valid = '0;
      @(negedge clk);
      chk("cdb_r2_next", src1_rdy[1], 1);
      chk("cdb_r3_next", src1_rdy[2], 1);
      chk("cdb_r1_next", src1_rdy[0], 0);

      // branch in middle of group
      tick;
      clr;
      dis_valid = 3'b111;
      dis_dest_arch[0] = 5; dis_new_tag[0] = 20;
      dis_is_branch[1] = 1'b1;
      dis_dest_arch[2] = 5; dis_new_tag[2] = 21;
      dis_src1_arch[2] = 5;
      @(negedge clk);
      chk("br_id1", ckpt_id[1], 0);
      chk("br_old0", old_tag[0], 5);
      chk("br_old2", old_tag[2], 20);
      chk("br_fwd_tag", src1_tag[2], 20);
      chk("br_fwd_rdy", src1_rdy[2], 0);
      chk("br_free_pre", ckpt_free_cnt, 4);

      // CDB 20 reaches the checkpoint only; live r5 is 21
      tick;
      clr;
      cdb_valid[0] = 1'b1; cdb_tag[0] = 20;
      dis_src1_arch[0] = 5;
      @(negedge clk);
      chk("live_r5_tag", src1_tag[0], 21);
      chk("live_r5_rdy", src1_rdy[0], 0);
      chk("br_free_post", ckpt_free_cnt, 3);

      // mispredict id 0 with a dispatch that must be dropped
      tick;
      clr;
      br_mispredict = 1'b1; br_id = 0;
      dis_valid[0] = 1'b1; dis_dest_arch[0] = 6; dis_new_tag[0] = 30;
      tick;
      clr;
      dis_src1_arch[0] = 5; dis_src1_arch[1] = 6; dis_src1_arch[2] = 1;
      dis_src2_arch[0] = 2;
      ckpt_retire = 1'b1;
      @(negedge clk);
      chk("mp_r5_tag", src1_tag[0], 20);
      chk("mp_r5_rdy", src1_rdy[0], 1);
      chk("mp_r6_tag", src1_tag[1], 6);
      chk("mp_r6_rdy", src1_rdy[1], 1);
      chk("mp_r1_tag", src1_tag[2], 10);
      chk("mp_r1_rdy", src1_rdy[2], 0);
      chk("mp_r2_tag", src2_tag[0], 11);
      chk("mp_free", ckpt_free_cnt, 3);
      tick;
      clr;
      @(negedge clk);
      chk("ret_free", ckpt_free_cnt, 4);

      // wrap-around sequence from a fresh reset
      tick;
      rst = 1'b0;
      tick;
      rst = 1'b1;
      dis_valid = 3'b111; dis_is_branch = 3'b111;
      @(negedge clk);
      chk("wr_id0", ckpt_id[0], 0);
      chk("wr_id1", ckpt_id[1], 1);
      chk("wr_id2", ckpt_id[2], 2);
      tick;
      clr;
      dis_valid = 3'b001; dis_is_branch = 3'b001;
      @(negedge clk);
      chk("wr_id3", ckpt_id[0], 3);
      chk("wr_free1", ckpt_free_cnt, 1);
      tick;
      clr;
      ckpt_retire = 1'b1;
      @(negedge clk);
      chk("wr_full", ckpt_free_cnt, 0);
      tick;
      @(negedge clk);
      chk("wr_ret1", ckpt_free_cnt, 1);
      tick;
      clr;
      dis_valid = 3'b011; dis_is_branch = 3'b011;
      @(negedge clk);
      chk("wr_free2", ckpt_free_cnt, 2);
      chk("wr_id4", ckpt_id[0], 0);
      chk("wr_id5", ckpt_id[1], 1);
      tick;
      clr;
      br_mispredict = 1'b1; br_id = 2;
      @(negedge clk);
      chk("wr_full2", ckpt_free_cnt, 0);
      tick;
      clr;
      dis_valid = 3'b011;
      dis_dest_arch[0] = 4; dis_new_tag[0] = 33;
      dis_is_branch[1] = 1'b1;
      @(negedge clk);
      chk("wr_mp_free", ckpt_free_cnt, 3);
      chk("wr_mp_tail", ckpt_id[1], 3);

      // full recovery overrides dispatch and mispredict
      tick;
      clr;
      dis_src1_arch[0] = 4;
      @(negedge clk);
      chk("pre_rec_r4", src1_tag[0], 33);
      chk("pre_rec_free", ckpt_free_cnt, 2);
      rec_enable = 1'b1;
      br_mispredict = 1'b1; br_id = 2;
      dis_valid[0] = 1'b1; dis_dest_arch[0] = 1; dis_new_tag[0] = 40;
      tick;
      clr;
      dis_valid = 3'b001;
      dis_dest_arch[0] = 0; dis_new_tag[0] = 50;
      dis_src1_arch[0] = 4;
      dis_src1_arch[1] = 0; dis_src2_arch[1] = 1;
      dis_src2_arch[2] = 0;
      @(negedge clk);
      chk("rec_r4_tag", src1_tag[0], 4);
      chk("rec_r4_rdy", src1_rdy[0], 1);
      chk("rec_r1_tag", src2_tag[1], 1);
      chk("rec_r1_rdy", src2_rdy[1], 1);
      chk("rec_free", ckpt_free_cnt, 4);
      chk("r0_old", old_tag[0], 0);
      chk("r0_s1_tag", src1_tag[1], 0);
      chk("r0_s1_rdy", src1_rdy[1], 1);
      chk("r0_s2_tag", src2_tag[2], 0);
      chk("r0_s2_rdy", src2_rdy[2], 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
